// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Purpose: hazard unit for a 5-stage pipeline with delayed branches.
// It has three jobs:
//   - operand forwarding: chooses the source of each ID operand. Priority is
//     EX, then MEM, then WB, then the register file.
//   - load-use stalls: holds PC, nPC and IF/ID for one cycle and injects a
//     NOP into ID/EX.
//   - annulled branches: a two-state FSM (RUN/ANNUL) that turns the delay
//     slot into a NOP.
//
// Ports:
//   Clk                         pipeline clock, rising edge
//   R                           asynchronous reset, active low
//   ID_rs1/ID_rs2/ID_rd         ID-stage source register fields
//                               (ID_rd is the store-data source)
//   ID_use_rs1/_rs2/_rd         the matching source field is really read
//   ID_B_instr                  branch in ID
//   ID_29_a                     annul bit of that branch
//   ID_cond_true                branch condition is met
//   ID_cond_always              branch is BA-type
//   EX_RD/MEM_RD/WB_RD          destination register of each later stage
//   EX/MEM/WB_RF_enable         that stage writes the register file
//   EX_load_instr               the instruction in EX is a load
//   LE                          load enable for PC, nPC and IF/ID
//   S                           1 = inject a NOP into ID/EX
//   Branch_sel                  1 = nPC loads the branch target
//   FWD_PA/FWD_PB/FWD_PD        operand source: 00 RF, 01 EX, 10 MEM, 11 WB
//   Stall_count/Annul_count     saturating statistics counters
//                               (present only with HAZARD_STATS_EN)
//
// Configuration: define HAZARD_STATS_EN to build the statistics counters.
// ---------------------------------------------------------------------------
module pipeline_hazard_controller (
    input  logic        Clk,
    input  logic        R,
    input  logic [4:0]  ID_rs1,
    input  logic [4:0]  ID_rs2,
    input  logic [4:0]  ID_rd,
    input  logic        ID_use_rs1,
    input  logic        ID_use_rs2,
    input  logic        ID_use_rd,
    input  logic        ID_B_instr,
    input  logic        ID_29_a,
    input  logic        ID_cond_true,
    input  logic        ID_cond_always,
    input  logic [4:0]  EX_RD,
    input  logic [4:0]  MEM_RD,
    input  logic [4:0]  WB_RD,
    input  logic        EX_RF_enable,
    input  logic        MEM_RF_enable,
    input  logic        WB_RF_enable,
    input  logic        EX_load_instr,
    output logic        LE,
    output logic        S,
    output logic        Branch_sel,
    output logic [1:0]  FWD_PA,
    output logic [1:0]  FWD_PB,
    output logic [1:0]  FWD_PD
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] Stall_count,
    output logic [15:0] Annul_count
`endif
);

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_ANNUL = 1'b1;

    logic state;
    logic state_next;
    logic load_use;
    logic annul_req;
    logic le_int;
    logic s_int;
    logic bsel_int;

    // Returns the forwarding select for one operand. Register r0 and unused
    // fields always read the register file.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       used,
        input logic [4:0] ex_rd,
        input logic       ex_en,
        input logic [4:0] mem_rd,
        input logic       mem_en,
        input logic [4:0] wb_rd,
        input logic       wb_en
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && (src != 5'd0)) begin
            if (ex_en && (ex_rd == src))
                sel = 2'b01;
            else if (mem_en && (mem_rd == src))
                sel = 2'b10;
            else if (wb_en && (wb_rd == src))
                sel = 2'b11;
        end
        return sel;
    endfunction

    // A load in EX whose result is needed by ID. The check is masked while
    // annulling, because the NOP injected in that cycle consumes nothing.
    always_comb begin
        load_use = 1'b0;
        if ((state == ST_RUN) && EX_load_instr && EX_RF_enable && (EX_RD != 5'd0)) begin
            load_use = (ID_use_rs1 && (ID_rs1 == EX_RD)) ||
                       (ID_use_rs2 && (ID_rs2 == EX_RD)) ||
                       (ID_use_rd  && (ID_rd  == EX_RD));
        end
    end

    // A stall holds the branch in ID, so both the branch decision and the
    // annul request wait until the stall cycle has passed.
    always_comb begin
        le_int     = 1'b1;
        s_int      = 1'b0;
        bsel_int   = 1'b0;
        annul_req  = 1'b0;
        state_next = ST_RUN;
        if (state == ST_ANNUL) begin
            s_int = 1'b1;
        end else if (load_use) begin
            le_int = 1'b0;
            s_int  = 1'b1;
        end else if (ID_B_instr) begin
            bsel_int  = ID_cond_true | ID_cond_always;
            annul_req = ID_29_a & (~ID_cond_true | ID_cond_always);
        end
        if (annul_req)
            state_next = ST_ANNUL;
    end

    always_ff @(posedge Clk or negedge R) begin
        if (!R)
            state <= ST_RUN;
        else
            state <= state_next;
    end

    // While reset is held, the outputs are forced to the stalled, safe values.
    // This does not wait for a clock edge.
    always_comb begin
        LE         = R ? le_int   : 1'b0;
        S          = R ? s_int    : 1'b1;
        Branch_sel = R ? bsel_int : 1'b0;
        FWD_PA     = R ? fwd_sel(ID_rs1, ID_use_rs1, EX_RD, EX_RF_enable,
                                 MEM_RD, MEM_RF_enable, WB_RD, WB_RF_enable) : 2'b00;
        FWD_PB     = R ? fwd_sel(ID_rs2, ID_use_rs2, EX_RD, EX_RF_enable,
                                 MEM_RD, MEM_RF_enable, WB_RD, WB_RF_enable) : 2'b00;
        FWD_PD     = R ? fwd_sel(ID_rd, ID_use_rd, EX_RD, EX_RF_enable,
                                 MEM_RD, MEM_RF_enable, WB_RD, WB_RF_enable) : 2'b00;
    end

`ifdef HAZARD_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            Stall_count <= 16'd0;
            Annul_count <= 16'd0;
        end else begin
            if (load_use)
                Stall_count <= sat_inc(Stall_count);
            if (state == ST_ANNUL)
                Annul_count <= sat_inc(Annul_count);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

    logic       Clk = 1'b0;
    logic       R   = 1'b0;
    logic [4:0] ID_rs1, ID_rs2, ID_rd;
    logic       ID_use_rs1, ID_use_rs2, ID_use_rd;
    logic       ID_B_instr, ID_29_a, ID_cond_true, ID_cond_always;
    logic [4:0] EX_RD, MEM_RD, WB_RD;
    logic       EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load_instr;
    logic       LE, S, Branch_sel;
    logic [1:0] FWD_PA, FWD_PB, FWD_PD;
`ifdef HAZARD_STATS_EN
    logic [15:0] Stall_count, Annul_count;
`endif

    pipeline_hazard_controller dut (
        .Clk(Clk), .R(R),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .ID_use_rd(ID_use_rd),
        .ID_B_instr(ID_B_instr), .ID_29_a(ID_29_a),
        .ID_cond_true(ID_cond_true), .ID_cond_always(ID_cond_always),
        .EX_RD(EX_RD), .MEM_RD(MEM_RD), .WB_RD(WB_RD),
        .EX_RF_enable(EX_RF_enable), .MEM_RF_enable(MEM_RF_enable),
        .WB_RF_enable(WB_RF_enable), .EX_load_instr(EX_load_instr),
        .LE(LE), .S(S), .Branch_sel(Branch_sel),
        .FWD_PA(FWD_PA), .FWD_PB(FWD_PB), .FWD_PD(FWD_PD)
`ifdef HAZARD_STATS_EN
        , .Stall_count(Stall_count), .Annul_count(Annul_count)
`endif
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: "the next cycle is an annulled delay slot".
    bit m_annul      = 1'b0;
    bit m_annul_next = 1'b0;
    bit stall_now    = 1'b0;
    bit annul_now    = 1'b0;
    int m_stall_cnt  = 0;
    int m_annul_cnt  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Youngest writing stage that targets the source wins.
    function automatic logic [1:0] ref_fwd(input logic [4:0] src, input logic used);
        logic [4:0] rd[3];
        logic       en[3];
        rd = '{EX_RD, MEM_RD, WB_RD};
        en = '{EX_RF_enable, MEM_RF_enable, WB_RF_enable};
        if (!used || src == 5'd0) return 2'b00;
        for (int i = 0; i < 3; i++)
            if (en[i] && rd[i] == src) return 2'(i + 1);
        return 2'b00;
    endfunction

    task automatic verify(input string tag);
        logic [4:0] src[3];
        logic       use_b[3];
        bit         hit;
        bit         exp_bsel;
        if (!R) begin
            m_annul_next = 1'b0;
            stall_now    = 1'b0;
            annul_now    = 1'b0;
            m_stall_cnt  = 0;
            m_annul_cnt  = 0;
            check({tag, ".rst.LE"}, 16'(LE), 16'd0);
            check({tag, ".rst.S"}, 16'(S), 16'd1);
            check({tag, ".rst.BSEL"}, 16'(Branch_sel), 16'd0);
            check({tag, ".rst.FPA"}, 16'(FWD_PA), 16'd0);
            check({tag, ".rst.FPB"}, 16'(FWD_PB), 16'd0);
            check({tag, ".rst.FPD"}, 16'(FWD_PD), 16'd0);
        end else begin
            src   = '{ID_rs1, ID_rs2, ID_rd};
            use_b = '{ID_use_rs1, ID_use_rs2, ID_use_rd};
            hit = 1'b0;
            for (int i = 0; i < 3; i++)
                if (use_b[i] && src[i] == EX_RD) hit = 1'b1;
            stall_now = !m_annul && EX_load_instr && EX_RF_enable && (EX_RD != 5'd0) && hit;
            annul_now = m_annul;
            exp_bsel  = !m_annul && !stall_now && ID_B_instr && (ID_cond_true || ID_cond_always);
            m_annul_next = !m_annul && !stall_now && ID_B_instr && ID_29_a &&
                           (!ID_cond_true || ID_cond_always);
            check({tag, ".LE"}, 16'(LE), 16'(!stall_now));
            check({tag, ".S"}, 16'(S), 16'(m_annul || stall_now));
            check({tag, ".BSEL"}, 16'(Branch_sel), 16'(exp_bsel));
            check({tag, ".FPA"}, 16'(FWD_PA), 16'(ref_fwd(ID_rs1, ID_use_rs1)));
            check({tag, ".FPB"}, 16'(FWD_PB), 16'(ref_fwd(ID_rs2, ID_use_rs2)));
            check({tag, ".FPD"}, 16'(FWD_PD), 16'(ref_fwd(ID_rd, ID_use_rd)));
        end
`ifdef HAZARD_STATS_EN
        check({tag, ".STALLC"}, Stall_count, 16'(m_stall_cnt));
        check({tag, ".ANNC"}, Annul_count, 16'(m_annul_cnt));
`endif
    endtask

    task automatic cycle();
        @(posedge Clk);
        if (R) begin
            m_annul = m_annul_next;
            if (stall_now && m_stall_cnt < 65535) m_stall_cnt++;
            if (annul_now && m_annul_cnt < 65535) m_annul_cnt++;
        end else begin
            m_annul = 1'b0;
        end
        #1;
    endtask

    task automatic step(input string tag);
        #1;
        verify(tag);
        cycle();
    endtask

    task automatic clear_inputs();
        {ID_rs1, ID_rs2, ID_rd} = '0;
        {ID_use_rs1, ID_use_rs2, ID_use_rd} = '0;
        {ID_B_instr, ID_29_a, ID_cond_true, ID_cond_always} = '0;
        {EX_RD, MEM_RD, WB_RD} = '0;
        {EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load_instr} = '0;
    endtask

    task automatic random_inputs();
        ID_rs1 = 5'($urandom_range(0, 3));
        ID_rs2 = 5'($urandom_range(0, 3));
        ID_rd  = 5'($urandom_range(0, 3));
        {ID_use_rs1, ID_use_rs2, ID_use_rd} = 3'($urandom);
        ID_B_instr     = ($urandom_range(0, 9) < 3);
        {ID_29_a, ID_cond_true, ID_cond_always} = 3'($urandom);
        EX_RD  = 5'($urandom_range(0, 3));
        MEM_RD = 5'($urandom_range(0, 3));
        WB_RD  = 5'($urandom_range(0, 3));
        {EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load_instr} = 4'($urandom);
    endtask

    initial begin
        clear_inputs();
        R = 1'b0;
        @(posedge Clk);
        #1;
        // Reset held: outputs forced regardless of inputs.
        random_inputs();
        step("reset0");
        random_inputs();
        step("reset1");

        // First cycle after release, plain EX forwarding.
        clear_inputs();
        R = 1'b1;
        EX_RD = 5'd5; EX_RF_enable = 1'b1; ID_rs1 = 5'd5; ID_use_rs1 = 1'b1;
        step("fwd_ex");
        check("fwd_ex.direct", 16'(FWD_PA === 2'b01), 16'd1);

        // Load to r8 used by rs2: one stall, then MEM forwarding.
        clear_inputs();
        EX_RD = 5'd8; EX_RF_enable = 1'b1; EX_load_instr = 1'b1;
        ID_rs2 = 5'd8; ID_use_rs2 = 1'b1;
        step("load_use");
        clear_inputs();
        MEM_RD = 5'd8; MEM_RF_enable = 1'b1; ID_rs2 = 5'd8; ID_use_rs2 = 1'b1;
        step("load_use.after");

        // MEM beats WB; r0 is never forwarded.
        clear_inputs();
        MEM_RD = 5'd3; MEM_RF_enable = 1'b1; WB_RD = 5'd3; WB_RF_enable = 1'b1;
        ID_rd = 5'd3; ID_use_rd = 1'b1;
        step("mem_wb");
        clear_inputs();
        EX_RD = 5'd0; EX_RF_enable = 1'b1; ID_rs1 = 5'd0; ID_use_rs1 = 1'b1;
        step("r0");

        // Annulled untaken branch, then BA,a. The annul cycle masks a load-use.
        clear_inputs();
        ID_B_instr = 1'b1; ID_29_a = 1'b1;
        step("br_a_nt");
        clear_inputs();
        EX_RD = 5'd2; EX_RF_enable = 1'b1; EX_load_instr = 1'b1;
        ID_rs1 = 5'd2; ID_use_rs1 = 1'b1;
        step("annul_mask");
        clear_inputs();
        step("run_again");
        ID_B_instr = 1'b1; ID_29_a = 1'b1; ID_cond_always = 1'b1;
        step("ba_a");
        clear_inputs();
        step("ba_a.annul");

        // Taken annulling branch blocked by a load-use stall.
        ID_B_instr = 1'b1; ID_29_a = 1'b1; ID_cond_true = 1'b1;
        EX_RD = 5'd4; EX_RF_enable = 1'b1; EX_load_instr = 1'b1;
        ID_rs1 = 5'd4; ID_use_rs1 = 1'b1;
        step("br_stall");
        EX_RD = 5'd0; EX_RF_enable = 1'b0; EX_load_instr = 1'b0;
        MEM_RD = 5'd4; MEM_RF_enable = 1'b1;
        step("br_stall.after");
        clear_inputs();
        step("br_stall.no_annul");

        // Back-to-back loads, each with its own hazard.
        EX_RD = 5'd6; EX_RF_enable = 1'b1; EX_load_instr = 1'b1;
        ID_rs1 = 5'd6; ID_use_rs1 = 1'b1;
        step("b2b.first");
        MEM_RD = 5'd6; MEM_RF_enable = 1'b1; EX_RD = 5'd0; EX_load_instr = 1'b0; EX_RF_enable = 1'b0;
        step("b2b.fwd1");
        EX_RD = 5'd7; EX_RF_enable = 1'b1; EX_load_instr = 1'b1;
        ID_rs1 = 5'd0; ID_use_rs1 = 1'b0; ID_rs2 = 5'd7; ID_use_rs2 = 1'b1;
        step("b2b.second");
        clear_inputs();
        MEM_RD = 5'd7; MEM_RF_enable = 1'b1; ID_rs2 = 5'd7; ID_use_rs2 = 1'b1;
        step("b2b.fwd2");

        // Asynchronous reset in the middle of an annul cycle.
        clear_inputs();
        ID_B_instr = 1'b1; ID_29_a = 1'b1;
        step("async.br");
        clear_inputs();
        #1;
        verify("async.annul");
        #1;
        R = 1'b0;
        #1;
        verify("async.rst");
        #1;
        R = 1'b1;
        cycle();
        step("async.after");

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 400; n++) begin
            random_inputs();
            R = ($urandom_range(0, 49) != 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; port list below, clock and reset first.
REQ-002 Clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 R  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 ID_rs1, ID_rs2, ID_rd  in  5 each  ID-stage source fields; ID_rd is the store-data source.
REQ-005 ID_use_rs1, ID_use_rs2, ID_use_rd  in  1 each  source field is actually read.
REQ-006 ID_B_instr, ID_29_a, ID_cond_true, ID_cond_always  in  1 each  branch in ID, annul bit, condition met, BA-type.
REQ-007 EX_RD, MEM_RD, WB_RD  in  5 each; EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load_instr  in  1 each.
REQ-008 LE  out  1  load enable for PC, nPC and IF/ID.
REQ-009 S  out  1  MuxControlSignal select; 1 = inject NOP into ID/EX.
REQ-010 Branch_sel  out  1  1 = nPC loads branch target.
REQ-011 FWD_PA, FWD_PB, FWD_PD  out  2 each  operand source: 00 RF, 01 EX, 10 MEM, 11 WB.
REQ-012 Stall_count, Annul_count  out  16 each  statistics (present only with HAZARD_STATS_EN).

Function
REQ-013 SHALL implement FSM states RUN, ANNUL; encoding free.
REQ-014 Forwarding SHALL be combinational, per operand: priority EX > MEM > WB > RF; match requires RF_enable=1, RD==source, source!=0, use bit=1.
REQ-015 Register r0 SHALL never be forwarded (select 00).
REQ-016 Load-use hazard: EX_load_instr=1, EX_RF_enable=1, EX_RD!=0, EX_RD matches any used ID source -> same cycle LE=0, S=1, Branch_sel=0.
REQ-017 Load-use stall SHALL last exactly one cycle per load; next cycle the load is in MEM and FWD selects 10.
REQ-018 Branch in ID, no stall, state RUN: Branch_sel = ID_cond_true | ID_cond_always.
REQ-019 Annul: branch in ID with ID_29_a=1 and (ID_cond_true=0 or ID_cond_always=1) -> FSM RUN->ANNUL at next edge.
REQ-020 ANNUL: S=1, LE=1, Branch_sel=0, hazard detection masked; FSM returns to RUN at next edge.
REQ-021 Stall has priority over branch: branch decision and annul transition deferred until stall clears.
REQ-022 Branch with ID_29_a=0: delay slot executes, no NOP, FSM stays RUN.
REQ-023 Normal RUN, no hazard: LE=1, S=0.
REQ-024 Back-to-back loads each producing a hazard SHALL each stall one cycle.

Reset
REQ-025 While R=0: FSM=RUN, LE=0, S=1, Branch_sel=0, FWD_*=00, counters=0, independent of Clk.
REQ-026 Reset asserted mid-ANNUL or mid-stall SHALL abort it; first cycle after release is RUN with no pending annul.
REQ-027 Outputs SHALL follow REQ-023/014 in the first cycle after R rises, with no spurious stall.

Configuration
REQ-028 Macro HAZARD_STATS_EN: defined -> Stall_count increments per load-use stall cycle, Annul_count per ANNUL cycle, both saturate at 16'hFFFF, cleared by reset.
REQ-029 HAZARD_STATS_EN undefined -> counter ports and logic absent; all other behaviour identical.

Verification
REQ-030 EX_RD=5, EX_RF_enable=1, EX_load_instr=0, ID_rs1=5 used -> FWD_PA=01, LE=1, S=0.
REQ-031 EX load to r8, ID_rs2=8 used -> one cycle LE=0, S=1; next cycle FWD_PB=10, LE=1, S=0; Stall_count=1 (stats on).
REQ-032 MEM_RD=3 and WB_RD=3 both writing, ID_rd=3 used -> FWD_PD=10; source r0 with EX_RD=0 -> 00.
REQ-033 Branch a=1, cond_true=0 -> Branch_sel=0, next cycle S=1 (ANNUL), then RUN; BA,a -> Branch_sel=1 then ANNUL.
REQ-034 Branch a=1 taken-cond with simultaneous load-use -> stall cycle first, then Branch_sel=1, no ANNUL.
REQ-035 R driven 0 during ANNUL, async mid-cycle -> immediately LE=0, S=1, counters 0; after release RUN, S=0.
